// File: rtl/alu_exec_unit.sv
// alu_exec_unit: decodes aluOp/funct3/funct7/opcode fields and runs one
// registered RV32I ALU or branch operation per handshake. Shifts execute on
// an iterative shifter that moves up to SHIFT_STEP bits per cycle.
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   inValid / inReady     operation handshake (aluOp, f3, f7, op, srcA, srcB)
//   outValid / outReady   result handshake (result, zero, branchTaken)
module alu_exec_unit #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned SHIFT_STEP = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            inValid,
  output logic            inReady,
  input  logic [1:0]      aluOp,
  input  logic [2:0]      f3,
  input  logic            f7,
  input  logic            op,
  input  logic [XLEN-1:0] srcA,
  input  logic [XLEN-1:0] srcB,
  output logic            outValid,
  input  logic            outReady,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            branchTaken
);

  localparam int unsigned SHW = $clog2(XLEN);
  // One extra bit so SHIFT_STEP == XLEN still fits in the step compare
  localparam int unsigned CW  = SHW + 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_e;

  state_e            state_q, state_d;
  logic [XLEN-1:0]   result_q, result_d;
  logic              zero_q, zero_d;
  logic              branch_q, branch_d;
  logic              valid_q, valid_d;
  logic [SHW-1:0]    rem_q, rem_d;
  logic              left_q, left_d;
  logic              arith_q, arith_d;

  logic              accept;
  logic [XLEN-1:0]   dec_res;
  logic              dec_br;
  logic              dec_shift;
  logic [SHW-1:0]    shamt;
  logic [CW-1:0]     rem_w;
  logic [CW-1:0]     step;
  logic              last_step;
  logic [XLEN-1:0]   shifted;

  assign inReady = rst_n && ((state_q == IDLE) || (state_q == DONE && outReady));
  assign accept  = inValid && inReady;
  assign shamt   = srcB[SHW-1:0];

  // Field decode and single-cycle ALU / branch compare
  always_comb begin : decode
    logic [XLEN-1:0] sum;
    logic [XLEN-1:0] diff;
    logic            lt;
    logic            ltu;
    sum       = srcA + srcB;
    diff      = srcA - srcB;
    lt        = $signed(srcA) < $signed(srcB);
    ltu       = srcA < srcB;
    dec_res   = sum;
    dec_br    = 1'b0;
    dec_shift = 1'b0;
    case (aluOp)
      2'b00: dec_res = sum;
      2'b01: begin
        dec_res = diff;
        case (f3)
          3'b000:  dec_br = (srcA == srcB);
          3'b001:  dec_br = (srcA != srcB);
          3'b100:  dec_br = lt;
          3'b101:  dec_br = !lt;
          3'b110:  dec_br = ltu;
          3'b111:  dec_br = !ltu;
          default: dec_br = 1'b0;
        endcase
      end
      2'b10: begin
        case (f3)
          3'b000: dec_res = (f7 && op) ? diff : sum;
          // Shifts report srcA directly; only used when shamt is zero
          3'b001: begin dec_shift = 1'b1; dec_res = srcA; end
          3'b010: dec_res = XLEN'(lt);
          3'b011: dec_res = XLEN'(ltu);
          3'b100: dec_res = srcA ^ srcB;
          3'b101: begin dec_shift = 1'b1; dec_res = srcA; end
          3'b110: dec_res = srcA | srcB;
          3'b111: dec_res = srcA & srcB;
          default: dec_res = sum;
        endcase
      end
      default: dec_res = srcB;
    endcase
  end

  // One iteration of the shifter: min(SHIFT_STEP, remaining) positions
  always_comb begin : shift_step
    rem_w     = CW'(rem_q);
    step      = (rem_w > CW'(SHIFT_STEP)) ? CW'(SHIFT_STEP) : rem_w;
    last_step = (rem_w <= CW'(SHIFT_STEP));
    if (left_q)       shifted = result_q << step;
    else if (arith_q) shifted = $signed(result_q) >>> step;
    else              shifted = result_q >> step;
  end

  // Next-state and next-output logic
  always_comb begin : next_state
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
    branch_d = branch_q;
    rem_d    = rem_q;
    left_d   = left_q;
    arith_d  = arith_q;
    case (state_q)
      SHIFT: begin
        result_d = shifted;
        rem_d    = rem_q - SHW'(step);
        if (last_step) begin
          state_d = DONE;
          zero_d  = (shifted == '0);
        end
      end
      DONE: if (outReady) state_d = IDLE;
      default: ;
    endcase
    // A new operation overrides drain-to-IDLE in the same cycle
    if (accept) begin
      branch_d = dec_br;
      if (dec_shift && (shamt != '0)) begin
        state_d  = SHIFT;
        result_d = srcA;
        zero_d   = 1'b0;
        rem_d    = shamt;
        left_d   = (f3 == 3'b001);
        arith_d  = (f3 == 3'b101) && f7;
      end else begin
        state_d  = DONE;
        result_d = dec_res;
        zero_d   = (dec_res == '0);
      end
    end
    valid_d = (state_d == DONE);
  end

  // State and output registers
  always_ff @(posedge clk) begin : regs
    if (!rst_n) begin
      state_q  <= IDLE;
      result_q <= '0;
      zero_q   <= 1'b0;
      branch_q <= 1'b0;
      valid_q  <= 1'b0;
      rem_q    <= '0;
      left_q   <= 1'b0;
      arith_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      branch_q <= branch_d;
      valid_q  <= valid_d;
      rem_q    <= rem_d;
      left_q   <= left_d;
      arith_q  <= arith_d;
    end
  end

  assign outValid    = valid_q;
  assign result      = result_q;
  assign zero        = zero_q;
  assign branchTaken = branch_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit (XLEN = 32, SHIFT_STEP = 4).
module tb_alu_exec_unit;

  localparam int unsigned XLEN = 32;
  localparam int unsigned SS   = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            inValid;
  logic            inReady;
  logic [1:0]      aluOp;
  logic [2:0]      f3;
  logic            f7;
  logic            op;
  logic [XLEN-1:0] srcA;
  logic [XLEN-1:0] srcB;
  logic            outValid;
  logic            outReady;
  logic [XLEN-1:0] result;
  logic            zero;
  logic            branchTaken;

  int n_vec = 0;
  int n_bad = 0;

  alu_exec_unit #(.XLEN(XLEN), .SHIFT_STEP(SS)) dut (
    .clk(clk), .rst_n(rst_n), .inValid(inValid), .inReady(inReady),
    .aluOp(aluOp), .f3(f3), .f7(f7), .op(op), .srcA(srcA), .srcB(srcB),
    .outValid(outValid), .outReady(outReady), .result(result),
    .zero(zero), .branchTaken(branchTaken)
  );

  always #5 clk = ~clk;

  // Reference model: RV32I semantics written directly from the ISA rules
  function automatic void model(input logic [1:0] ao, input logic [2:0] fn3,
                                input logic fn7, input logic opb,
                                input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic br);
    int   sh;
    logic slt;
    sh  = int'(b[4:0]);
    slt = (a[31] != b[31]) ? a[31] : (a < b);
    br  = 1'b0;
    r   = 32'd0;
    case (ao)
      2'd0: r = a + b;
      2'd3: r = b;
      2'd1: begin
        r = a - b;
        case (fn3)
          3'd0: br = (a == b);
          3'd1: br = (a != b);
          3'd4: br = slt;
          3'd5: br = !slt;
          3'd6: br = (a < b);
          3'd7: br = (a >= b);
          default: br = 1'b0;
        endcase
      end
      default: begin
        case (fn3)
          3'd0: r = (fn7 && opb) ? a - b : a + b;
          3'd1: r = a << sh;
          3'd2: r = {31'd0, slt};
          3'd3: r = {31'd0, (a < b)};
          3'd4: r = a ^ b;
          3'd5: r = (fn7 && a[31]) ? ~((~a) >> sh) : (a >> sh);
          3'd6: r = a | b;
          default: r = a & b;
        endcase
      end
    endcase
  endfunction

  function automatic int exp_lat(input logic [1:0] ao, input logic [2:0] fn3,
                                 input logic [31:0] b);
    int sh;
    sh = int'(b[4:0]);
    if (ao == 2'd2 && (fn3 == 3'd1 || fn3 == 3'd5) && sh != 0)
      return (sh + int'(SS) - 1) / int'(SS) + 1;
    return 1;
  endfunction

  // Issue one op from IDLE, wait for the result, capture it, then drain it
  task automatic do_op(input logic [1:0] ao, input logic [2:0] fn3,
                       input logic fn7, input logic opb,
                       input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] r, output logic z, output logic br,
                       output int lat);
    @(negedge clk);
    aluOp = ao; f3 = fn3; f7 = fn7; op = opb; srcA = a; srcB = b;
    inValid = 1'b1; outReady = 1'b0;
    @(negedge clk);
    inValid = 1'b0;
    lat = 1;
    while (outValid !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (outValid !== 1'b1) lat = -1;
    r = result; z = zero; br = branchTaken;
    outReady = 1'b1;
    @(negedge clk);
    outReady = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; inValid = 1'b1; outReady = 1'b0;
    aluOp = 2'd0; f3 = 3'd0; f7 = 1'b0; op = 1'b0; srcA = 32'd1; srcB = 32'd2;
    @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (outValid !== 1'b0) begin n_bad++; $display("FAIL reset_outValid got %0b want 0", outValid); end
    n_vec++;
    if (result !== 32'd0) begin n_bad++; $display("FAIL reset_result got %h want 0", result); end
    n_vec++;
    if (inReady !== 1'b0) begin n_bad++; $display("FAIL reset_inReady got %0b want 0", inReady); end
    rst_n = 1'b1; inValid = 1'b0;
    #1;
    n_vec++;
    if (inReady !== 1'b1) begin n_bad++; $display("FAIL release_inReady got %0b want 1", inReady); end
  endtask

  task automatic test_arith;
    logic [31:0] r; logic z, br; int lat;
    do_op(2'd2, 3'd0, 1'b1, 1'b1, 32'd5, 32'd7, r, z, br, lat);
    n_vec++;
    if (r !== 32'hFFFFFFFE || z !== 1'b0 || lat != 1) begin
      n_bad++; $display("FAIL sub got r=%h z=%0b lat=%0d want r=fffffffe z=0 lat=1", r, z, lat);
    end
    do_op(2'd2, 3'd0, 1'b1, 1'b0, 32'd5, 32'd7, r, z, br, lat);
    n_vec++;
    if (r !== 32'd12 || lat != 1) begin
      n_bad++; $display("FAIL addi got r=%h lat=%0d want r=c lat=1", r, lat);
    end
  endtask

  task automatic test_shift;
    logic [31:0] r; logic z, br; int lat;
    do_op(2'd2, 3'd5, 1'b1, 1'b1, 32'h80000000, 32'd4, r, z, br, lat);
    n_vec++;
    if (r !== 32'hF8000000 || lat != exp_lat(2'd2, 3'd5, 32'd4)) begin
      n_bad++; $display("FAIL sra4 got r=%h lat=%0d want r=f8000000 lat=%0d", r, lat, exp_lat(2'd2, 3'd5, 32'd4));
    end
    do_op(2'd2, 3'd1, 1'b0, 1'b1, 32'h12345678, 32'hFFFFFFE0, r, z, br, lat);
    n_vec++;
    if (r !== 32'h12345678 || lat != 1) begin
      n_bad++; $display("FAIL sll0 got r=%h lat=%0d want r=12345678 lat=1", r, lat);
    end
    do_op(2'd2, 3'd1, 1'b0, 1'b0, 32'h00000003, 32'd31, r, z, br, lat);
    n_vec++;
    if (r !== 32'h80000000 || z !== 1'b0 || lat != 9) begin
      n_bad++; $display("FAIL sll31 got r=%h z=%0b lat=%0d want r=80000000 z=0 lat=9", r, z, lat);
    end
    do_op(2'd2, 3'd5, 1'b0, 1'b1, 32'h80000000, 32'd31, r, z, br, lat);
    n_vec++;
    if (r !== 32'd1 || lat != 9) begin
      n_bad++; $display("FAIL srl31 got r=%h lat=%0d want r=1 lat=9", r, lat);
    end
    do_op(2'd2, 3'd5, 1'b0, 1'b1, 32'h00000040, 32'd7, r, z, br, lat);
    n_vec++;
    if (r !== 32'd0 || z !== 1'b1 || lat != 3) begin
      n_bad++; $display("FAIL srl_zero got r=%h z=%0b lat=%0d want r=0 z=1 lat=3", r, z, lat);
    end
  endtask

  task automatic test_branch;
    logic [31:0] r; logic z, br; int lat;
    do_op(2'd1, 3'd4, 1'b0, 1'b0, 32'hFFFFFFFF, 32'd1, r, z, br, lat);
    n_vec++;
    if (br !== 1'b1) begin n_bad++; $display("FAIL blt got br=%0b want 1", br); end
    do_op(2'd1, 3'd6, 1'b0, 1'b0, 32'hFFFFFFFF, 32'd1, r, z, br, lat);
    n_vec++;
    if (br !== 1'b0) begin n_bad++; $display("FAIL bltu got br=%0b want 0", br); end
    do_op(2'd1, 3'd0, 1'b0, 1'b0, 32'd9, 32'd9, r, z, br, lat);
    n_vec++;
    if (br !== 1'b1 || z !== 1'b1) begin n_bad++; $display("FAIL beq got br=%0b z=%0b want 1 1", br, z); end
    do_op(2'd1, 3'd2, 1'b0, 1'b0, 32'd9, 32'd9, r, z, br, lat);
    n_vec++;
    if (br !== 1'b0) begin n_bad++; $display("FAIL b010 got br=%0b want 0", br); end
  endtask

  task automatic test_random;
    logic [31:0] r, a, b, er; logic z, br, ebr; int lat;
    logic [1:0] ao; logic [2:0] fn3; logic fn7, opb;
    for (int i = 0; i < 80; i++) begin
      ao  = 2'($urandom_range(0, 3));
      fn3 = 3'($urandom_range(0, 7));
      fn7 = 1'($urandom_range(0, 1));
      opb = 1'($urandom_range(0, 1));
      a   = $urandom;
      b   = ($urandom_range(0, 3) == 0) ? a : $urandom;
      if ($urandom_range(0, 3) == 0) a = {$urandom_range(0, 1) == 1, 31'd0};
      model(ao, fn3, fn7, opb, a, b, er, ebr);
      do_op(ao, fn3, fn7, opb, a, b, r, z, br, lat);
      n_vec++;
      if (r !== er || z !== (er == 32'd0) || br !== ebr || lat != exp_lat(ao, fn3, b)) begin
        n_bad++;
        $display("FAIL rand%0d ao=%0d f3=%0d f7=%0b op=%0b a=%h b=%h got r=%h z=%0b br=%0b lat=%0d want r=%h z=%0b br=%0b lat=%0d",
                 i, ao, fn3, fn7, opb, a, b, r, z, br, lat, er, (er == 32'd0), ebr, exp_lat(ao, fn3, b));
      end
    end
  endtask

  task automatic test_back_to_back;
    int wait_cnt;
    @(negedge clk);
    aluOp = 2'd0; f3 = 3'd0; f7 = 1'b0; op = 1'b0; srcA = 32'd100; srcB = 32'd23;
    inValid = 1'b1; outReady = 1'b0;
    @(negedge clk);
    srcA = 32'd1; srcB = 32'd2;
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (outValid !== 1'b1 || result !== 32'd123 || inReady !== 1'b0) begin
        n_bad++; $display("FAIL hold%0d got v=%0b r=%h rdy=%0b want 1 7b 0", i, outValid, result, inReady);
      end
      @(negedge clk);
    end
    outReady = 1'b1;
    #1;
    n_vec++;
    if (inReady !== 1'b1) begin n_bad++; $display("FAIL b2b_inReady got %0b want 1", inReady); end
    @(negedge clk);
    n_vec++;
    if (outValid !== 1'b1 || result !== 32'd3) begin
      n_bad++; $display("FAIL b2b_result got v=%0b r=%h want 1 3", outValid, result);
    end
    // Drain plus accept of a multi-cycle shift: outValid must drop
    aluOp = 2'd2; f3 = 3'd1; srcA = 32'd3; srcB = 32'd8;
    @(negedge clk);
    inValid = 1'b0; outReady = 1'b0;
    n_vec++;
    if (outValid !== 1'b0) begin n_bad++; $display("FAIL b2b_shift_drop got %0b want 0", outValid); end
    wait_cnt = 0;
    while (outValid !== 1'b1 && wait_cnt < 50) begin @(negedge clk); wait_cnt++; end
    n_vec++;
    if (outValid !== 1'b1 || result !== 32'h300 || wait_cnt != 2) begin
      n_bad++; $display("FAIL b2b_shift got v=%0b r=%h wait=%0d want 1 300 2", outValid, result, wait_cnt);
    end
    outReady = 1'b1;
    @(negedge clk);
    outReady = 1'b0;
  endtask

  task automatic test_reset_mid_shift;
    logic saw_valid;
    @(negedge clk);
    aluOp = 2'd2; f3 = 3'd1; f7 = 1'b0; op = 1'b1; srcA = 32'd1; srcB = 32'd31;
    inValid = 1'b1; outReady = 1'b0;
    @(negedge clk);
    inValid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    n_vec++;
    if (outValid !== 1'b0 || result !== 32'd0 || inReady !== 1'b0) begin
      n_bad++; $display("FAIL midshift_reset got v=%0b r=%h rdy=%0b want 0 0 0", outValid, result, inReady);
    end
    rst_n = 1'b1;
    #1;
    n_vec++;
    if (inReady !== 1'b1) begin n_bad++; $display("FAIL midshift_idle got rdy=%0b want 1", inReady); end
    saw_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (outValid !== 1'b0 || result !== 32'd0) saw_valid = 1'b1;
    end
    n_vec++;
    if (saw_valid !== 1'b0) begin n_bad++; $display("FAIL midshift_stale got 1 want 0"); end
  endtask

  initial begin
    test_reset();
    test_arith();
    test_shift();
    test_branch();
    test_back_to_back();
    test_random();
    test_reset_mid_shift();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
